lsu_mem_responder: RTL and testbench

Responder for the core's req/gnt/rvalid memory interface, i.e. the slave end of the `data_*`/`instr_*` request protocol the zeroriscy core initiates. It accepts pipelined requests, applies a configurable grant wait, decodes one address window onto a single-port SRAM with 1-cycle read latency, and returns exactly one `rvalid` per grant. Accesses outside the window complete with `err_o` asserted. It sits between the core (or one AXI-side port) and `sp_ram_wrap`/`instr_ram_wrap`.

---
 rtl/lsu_mem_responder.sv | 104 ++++++++++
 tb/tb_lsu_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// Slave end of the req/gnt/rvalid memory protocol: optional grant wait, one decoded
// address window onto a 1-cycle-latency single-port SRAM, error response outside it.
module lsu_mem_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          MEM_ADDR_WIDTH = 14,
  parameter int          WAIT_CYCLES    = 0
) (
  input  logic                      clk,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic                      err_o,
  input  logic [31:0]               addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               wdata_i,
  output logic [31:0]               rdata_o,
  output logic                      mem_en_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                      mem_we_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       we_q, we_d;
  logic       gnt;
  logic       in_range;
  logic       unused_addr_lsb;

  assign in_range        = (addr_i[31:MEM_ADDR_WIDTH+2] == BASE_ADDR[31:MEM_ADDR_WIDTH+2]);
  assign unused_addr_lsb = ^addr_i[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (WAIT_CYCLES == 0) begin
          gnt     = req_i;
          state_d = req_i ? RESP : IDLE;
        end else if (req_i) begin
          state_d = WAIT;
          cnt_d   = 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // A withdrawn request leaves silently: no SRAM access, no response.
        if (!req_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WaitCnt) begin
          gnt     = 1'b1;
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = gnt ? ~in_range : err_q;
  assign we_d  = gnt ? we_i : we_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  // Grant is combinational from req_i when WAIT_CYCLES is 0, so mask it during reset.
  assign gnt_o       = gnt & rst_ni;
  assign mem_en_o    = gnt_o & in_range;
  assign mem_addr_o  = addr_i[MEM_ADDR_WIDTH+1:2];
  assign mem_we_o    = we_i;
  assign mem_be_o    = be_i;
  assign mem_wdata_o = wdata_i;

  assign rvalid_o = (state_q == RESP);
  assign err_o    = rvalid_o & err_q;
  assign rdata_o  = (rvalid_o && !err_q && !we_q) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: three instances (WAIT_CYCLES 0, 2, 3), each
// backed by a behavioural 1-cycle-latency SRAM.
module tb_lsu_mem_responder;

  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req2, req3;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic          gnt0, rvalid0, err0, en0, mwe0;
  logic [31:0]   rdata0, mwdata0, mrdata0;
  logic [AW-1:0] maddr0;
  logic [3:0]    mbe0;
  logic          gnt2, rvalid2, err2, en2, mwe2;
  logic [31:0]   rdata2, mwdata2, mrdata2;
  logic [AW-1:0] maddr2;
  logic [3:0]    mbe2;
  logic          gnt3, rvalid3, err3, en3, mwe3;
  logic [31:0]   rdata3, mwdata3, mrdata3;
  logic [AW-1:0] maddr3;
  logic [3:0]    mbe3;

  logic [31:0] mem0 [0:(1<<AW)-1];
  logic [31:0] mem2 [0:(1<<AW)-1];
  logic [31:0] mem3 [0:(1<<AW)-1];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_responder #(.BASE_ADDR(32'h1000_0000), .MEM_ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_ni(rst_n), .req_i(req0), .gnt_o(gnt0), .rvalid_o(rvalid0), .err_o(err0),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rdata0),
    .mem_en_o(en0), .mem_addr_o(maddr0), .mem_we_o(mwe0), .mem_be_o(mbe0),
    .mem_wdata_o(mwdata0), .mem_rdata_i(mrdata0));

  lsu_mem_responder #(.BASE_ADDR(32'h1000_0000), .MEM_ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst_ni(rst_n), .req_i(req2), .gnt_o(gnt2), .rvalid_o(rvalid2), .err_o(err2),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rdata2),
    .mem_en_o(en2), .mem_addr_o(maddr2), .mem_we_o(mwe2), .mem_be_o(mbe2),
    .mem_wdata_o(mwdata2), .mem_rdata_i(mrdata2));

  lsu_mem_responder #(.BASE_ADDR(32'h1000_0000), .MEM_ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst_ni(rst_n), .req_i(req3), .gnt_o(gnt3), .rvalid_o(rvalid3), .err_o(err3),
    .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rdata3),
    .mem_en_o(en3), .mem_addr_o(maddr3), .mem_we_o(mwe3), .mem_be_o(mbe3),
    .mem_wdata_o(mwdata3), .mem_rdata_i(mrdata3));

  // Behavioural SRAMs: byte-masked write, registered read.
  always @(posedge clk) begin
    if (en0) begin
      for (int b = 0; b < 4; b++) if (mwe0 && mbe0[b]) mem0[maddr0][8*b +: 8] <= mwdata0[8*b +: 8];
      mrdata0 <= mem0[maddr0];
    end
    if (en2) begin
      for (int b = 0; b < 4; b++) if (mwe2 && mbe2[b]) mem2[maddr2][8*b +: 8] <= mwdata2[8*b +: 8];
      mrdata2 <= mem2[maddr2];
    end
    if (en3) begin
      for (int b = 0; b < 4; b++) if (mwe3 && mbe3[b]) mem3[maddr3][8*b +: 8] <= mwdata3[8*b +: 8];
      mrdata3 <= mem3[maddr3];
    end
  end

  task automatic drive(input logic r0, input logic r2, input logic r3, input logic [31:0] a,
                       input logic w, input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    req0 = r0; req2 = r2; req3 = r3; addr = a; we = w; be = b; wdata = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 4'hF, 32'h0);
    n_cmp++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    n_cmp++; if (en0 !== 1'b0) begin n_fail++; $display("FAIL reset_en0 got=%b exp=0", en0); end
    n_cmp++; if ({rvalid0, err0, rvalid2, rvalid3, gnt2, gnt3} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=000000", {rvalid0, err0, rvalid2, rvalid3, gnt2, gnt3}); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_rvalid0 got=%b exp=0", rvalid0); end
  endtask

  task automatic test_read_pipelined();
    drive(1'b1, 1'b0, 1'b0, 32'h1000_0000, 1'b0, 4'hF, 32'h0);
    n_cmp++; if ({gnt0, en0, rvalid0} !== 3'b110) begin
      n_fail++; $display("FAIL rd_c1 gnt/en/rvalid got=%b exp=110", {gnt0, en0, rvalid0}); end
    drive(1'b1, 1'b0, 1'b0, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
    n_cmp++; if ({gnt0, rvalid0, err0} !== 3'b110) begin
      n_fail++; $display("FAIL rd_c2 gnt/rvalid/err got=%b exp=110", {gnt0, rvalid0, err0}); end
    n_cmp++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_c2_data got=%h exp=DEADBEEF", rdata0); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if ({gnt0, rvalid0} !== 2'b01) begin
      n_fail++; $display("FAIL rd_c3 gnt/rvalid got=%b exp=01", {gnt0, rvalid0}); end
    n_cmp++; if (rdata0 !== 32'h12345678) begin n_fail++; $display("FAIL rd_c3_data got=%h exp=12345678", rdata0); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if (rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rd_c4_rvalid got=%b exp=0", rvalid0); end
  endtask

  task automatic test_write_then_read();
    drive(1'b1, 1'b0, 1'b0, 32'h1000_0010, 1'b1, 4'b0011, 32'hAABBCCDD);
    n_cmp++; if ({gnt0, en0, mwe0} !== 3'b111) begin
      n_fail++; $display("FAIL wr_grant gnt/en/we got=%b exp=111", {gnt0, en0, mwe0}); end
    n_cmp++; if ({mbe0, mwdata0, maddr0} !== {4'b0011, 32'hAABBCCDD, 14'd4}) begin
      n_fail++; $display("FAIL wr_passthru be=%b wdata=%h maddr=%0d exp be=0011 wdata=AABBCCDD maddr=4", mbe0, mwdata0, maddr0); end
    drive(1'b1, 1'b0, 1'b0, 32'h1000_0010, 1'b0, 4'hF, 32'h0);
    n_cmp++; if ({gnt0, rvalid0, err0} !== 3'b110) begin
      n_fail++; $display("FAIL wr_resp gnt/rvalid/err got=%b exp=110", {gnt0, rvalid0, err0}); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL wr_resp_data got=%h exp=0", rdata0); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if (rvalid0 !== 1'b1) begin n_fail++; $display("FAIL wr_rd_rvalid got=%b exp=1", rvalid0); end
    n_cmp++; if (rdata0 !== 32'h0000CCDD) begin n_fail++; $display("FAIL wr_rd_data got=%h exp=0000CCDD", rdata0); end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b0, 1'b0, 32'h2000_0000, 1'b0, 4'hF, 32'h0);
    n_cmp++; if ({gnt0, en0} !== 2'b10) begin
      n_fail++; $display("FAIL oor_grant gnt/en got=%b exp=10", {gnt0, en0}); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if ({rvalid0, err0} !== 2'b11) begin
      n_fail++; $display("FAIL oor_resp rvalid/err got=%b exp=11", {rvalid0, err0}); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL oor_rdata got=%h exp=0", rdata0); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if ({rvalid0, err0} !== 2'b00) begin
      n_fail++; $display("FAIL oor_after rvalid/err got=%b exp=00", {rvalid0, err0}); end
  endtask

  task automatic test_wait2();
    logic [2:0] exp_g, exp_e, exp_v;
    exp_g = 3'b100; exp_e = 3'b100; exp_v = 3'b000;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h1000_0000, 1'b0, 4'hF, 32'h0);
      n_cmp++; if ({gnt2, en2, rvalid2} !== {exp_g[c], exp_e[c], exp_v[c]}) begin
        n_fail++; $display("FAIL wait2_c%0d gnt/en/rvalid got=%b exp=%b", c, {gnt2, en2, rvalid2}, {exp_g[c], exp_e[c], exp_v[c]}); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if ({gnt2, en2, rvalid2, err2} !== 4'b0010) begin
      n_fail++; $display("FAIL wait2_c3 gnt/en/rvalid/err got=%b exp=0010", {gnt2, en2, rvalid2, err2}); end
    n_cmp++; if (rdata2 !== 32'h5A5A0001) begin n_fail++; $display("FAIL wait2_data got=%h exp=5A5A0001", rdata2); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if (rvalid2 !== 1'b0) begin n_fail++; $display("FAIL wait2_c4_rvalid got=%b exp=0", rvalid2); end
  endtask

  task automatic test_withdraw_and_reset();
    int lat;
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
    n_cmp++; if (gnt3 !== 1'b0) begin n_fail++; $display("FAIL wd_c0_gnt got=%b exp=0", gnt3); end
    drive(1'b0, 1'b0, 1'b0, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
    n_cmp++; if (gnt3 !== 1'b0) begin n_fail++; $display("FAIL wd_c1_gnt got=%b exp=0", gnt3); end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
      n_cmp++; if ({gnt3, en3, rvalid3} !== 3'b000) begin
        n_fail++; $display("FAIL wd_idle_c%0d gnt/en/rvalid got=%b exp=000", c, {gnt3, en3, rvalid3}); end
    end
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
    n_cmp++; if ({gnt3, gnt0} !== 2'b01) begin
      n_fail++; $display("FAIL rst_pre gnt3/gnt0 got=%b exp=01", {gnt3, gnt0}); end
    // u3 is mid-WAIT and u0 is in RESP when reset drops.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      n_cmp++; if ({gnt3, rvalid3, err3, en3} !== 4'b0000 || rdata3 !== 32'h0) begin
        n_fail++; $display("FAIL rst_u3_c%0d gnt/rvalid/err/en got=%b rdata=%h exp=0000 0", c, {gnt3, rvalid3, err3, en3}, rdata3); end
      n_cmp++; if ({gnt0, rvalid0, en0} !== 3'b000) begin
        n_fail++; $display("FAIL rst_u0_c%0d gnt/rvalid/en got=%b exp=000", c, {gnt0, rvalid0, en0}); end
      @(negedge clk); #1;
    end
    rst_n = 1'b1;
    req3 = 1'b0; req0 = 1'b1; addr = 32'h1000_0000;
    #1;
    n_cmp++; if ({gnt0, rvalid0, rvalid3} !== 3'b100) begin
      n_fail++; $display("FAIL rel_c0 gnt0/rvalid0/rvalid3 got=%b exp=100", {gnt0, rvalid0, rvalid3}); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if ({rvalid0, rvalid3} !== 2'b10 || rdata0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rel_c1 rvalid0/rvalid3=%b rdata0=%h exp=10 DEADBEEF", {rvalid0, rvalid3}, rdata0); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      n_cmp++; if (rvalid3 !== 1'b0) begin n_fail++; $display("FAIL rel_rvalid3_c%0d got=%b exp=0", c, rvalid3); end
    end
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      if (gnt3) begin lat = k; break; end
      @(negedge clk); #1;
    end
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL u3_grant_latency got=%0d exp=3", lat); end
    n_cmp++; if (en3 !== 1'b1) begin n_fail++; $display("FAIL u3_grant_en got=%b exp=1", en3); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    n_cmp++; if (rvalid3 !== 1'b1 || rdata3 !== 32'hC0FFEE03) begin
      n_fail++; $display("FAIL u3_resp rvalid=%b rdata=%h exp=1 C0FFEE03", rvalid3, rdata3); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [0:15];
    logic [31:0] expq [$];
    logic [31:0] exp_d, cur;
    int          n_gnt, n_rsp;
    logic        r, w;
    logic [3:0]  idx, b;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    n_gnt = 0; n_rsp = 0;
    for (int c = 0; c < 258; c++) begin
      r   = (c < 256) ? ($urandom_range(0, 3) != 0) : 1'b0;
      w   = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      d   = $urandom;
      drive(r, 1'b0, 1'b0, 32'h1000_0100 + {26'd0, idx, 2'b00} + 32'($urandom_range(0, 3)), w, b, d);
      if (rvalid0) begin
        n_rsp++;
        exp_d = (expq.size() != 0) ? expq.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (rdata0 !== exp_d || err0 !== 1'b0) begin
          n_fail++; $display("FAIL b2b_resp%0d rdata=%h err=%b exp=%h 0", n_rsp, rdata0, err0, exp_d); end
      end
      n_cmp++; if (gnt0 !== r) begin n_fail++; $display("FAIL b2b_gnt_c%0d got=%b exp=%b", c, gnt0, r); end
      if (gnt0) begin
        n_gnt++;
        cur = model[idx];
        expq.push_back(w ? 32'h0 : cur);
        if (w) for (int k = 0; k < 4; k++) if (b[k]) cur[8*k +: 8] = d[8*k +: 8];
        model[idx] = cur;
      end
    end
    n_cmp++; if (n_rsp != n_gnt || n_gnt == 0) begin
      n_fail++; $display("FAIL b2b_count responses=%0d grants=%0d", n_rsp, n_gnt); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem0[i] = 32'h0; mem2[i] = 32'h0; mem3[i] = 32'h0;
    end
    mem0[0] = 32'hDEADBEEF;
    mem0[1] = 32'h12345678;
    mem2[0] = 32'h5A5A0001;
    mem3[1] = 32'hC0FFEE03;
    req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
    addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    test_reset();
    test_read_pipelined();
    test_write_then_read();
    test_out_of_range();
    test_wait2();
    test_withdraw_and_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
